alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Micro-sequencer that drives the ALU operand-select mux and ALU operation code for the core datapath. It accepts one macro-operation at a time from the instruction decoder and walks it through a fixed list of 1–3 ALU steps. Each step selects IR, R5, R1, IDX or IDY, holds the ALU op for the required number of cycles, and strobes the accumulator write. Completion is reported with a DONE pulse. Illegal opcodes are reported with an ERR pulse.

## Interface
- MUL_CYCLES, 3, cycles a MUL step holds its operands (legal range 1–7)
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only while BUSY=0
- OPCODE  in  3  macro-op; latched with START
- ALUMUX  out  3  operand select: 001 IR, 101 R5, 100 R1, 010 IDX, 011 IDY
- ALUOP  out  3  000 NOP, 001 PASS, 010 ADD, 011 SUB, 100 MUL, 101 INC
- ACC_WE  out  1  accumulator write enable; high in the last cycle of each step
- BUSY  out  1  a sequence is in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle illegal-opcode pulse

## Operation
- Reset values: ALUMUX=001, ALUOP=000, ACC_WE=0, BUSY=0, DONE=0, ERR=0. State is IDLE, step index is 0, cycle counter is 0.
- All outputs are registered.
- Macro-ops, as (ALUMUX, ALUOP) steps in order:
  - 001 LDI: (IR, PASS)
  - 010 ADDR1: (R1, ADD)
  - 011 SUBR1: (R1, SUB)
  - 100 MULR5: (R5, MUL)
  - 101 ADDR: (IDX, PASS), (IDY, ADD), (R5, ADD)
  - 110 INCX: (IDX, INC)
- Illegal opcodes are 000 and 111.
- States:
  - IDLE → STEP when START=1 and the opcode is legal.
  - IDLE stays in IDLE and pulses ERR when START=1 and the opcode is illegal.
  - STEP → STEP on step advance.
  - STEP → FIN after the last step's final cycle.
  - FIN → IDLE unconditionally.
- STEP behaviour:
  - ALUMUX and ALUOP show the current step.
  - A non-MUL step lasts 1 cycle.
  - A MUL step lasts MUL_CYCLES cycles, counted by a 3-bit counter. The counter clears at each step boundary.
- ACC_WE is 1 only in the final cycle of each step. For ADDR it is therefore high in 3 consecutive cycles.
- FIN: ALUMUX=001, ALUOP=000, ACC_WE=0, BUSY=0, DONE=1.
- START is accepted in FIN, and the sequencer then goes directly to STEP of the new op. This keeps back-to-back throughput at one idle-free cycle per op boundary.
- BUSY=1 in every STEP cycle. It is 0 in IDLE and FIN.
- START while BUSY=1 is ignored; OPCODE changes while BUSY=1 have no effect.
- In IDLE, ALUMUX/ALUOP return to 001/000.

## Timing
- START sampled at edge 0. Step 0 is visible in cycle 1.
- Sequence lengths:
  - 1-step non-MUL op: DONE in cycle 2.
  - ADDR: steps in cycles 1–3, DONE in cycle 4.
  - MULR5: MUL in cycles 1..MUL_CYCLES, ACC_WE in cycle MUL_CYCLES, DONE in cycle MUL_CYCLES+1.
- ERR is high in cycle 1 after an illegal START. BUSY and DONE stay 0.
- MUL_CYCLES=1 behaves as a single-cycle step; the counter must not wrap.
- rstn low at any time forces the reset values immediately, without waiting for clk. An in-flight sequence is discarded with no DONE and no ACC_WE.
- The first START is honoured at the first rising edge after rstn deasserts.
- START and FIN in the same cycle: DONE=1 for the old op, and the new op's step 0 appears next cycle.

## Test plan
- Reset, then START with OPCODE=101 → cycle 1: ALUMUX=010/ALUOP=001; cycle 2: 011/010; cycle 3: 101/010. ACC_WE=1 in cycles 1–3, BUSY=1 in cycles 1–3, DONE=1 in cycle 4 only.
- MUL_CYCLES=3, OPCODE=100 → ALUMUX=101 and ALUOP=100 held for cycles 1–3, ACC_WE only in cycle 3, DONE in cycle 4. Repeat with MUL_CYCLES=1 → DONE in cycle 2.
- START with OPCODE=111, then 000 → ERR=1 for one cycle each, BUSY=0, ALUMUX=001 throughout.
- START with OPCODE=110, then re-assert START with OPCODE=001 while BUSY=1 → the second request is ignored and the INCX sequence completes unchanged. START with OPCODE=001 in the FIN cycle → DONE=1 in that cycle, ALUMUX=001/ALUOP=001 next cycle, with ACC_WE=1.
- Deassert rstn in cycle 2 of ADDR, asynchronously mid-cycle → outputs return to reset values before the next edge. After release, no DONE appears. A new START with OPCODE=010 → ALUMUX=100/ALUOP=010 in cycle 1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Micro-sequencer that walks one macro-op through 1-3 ALU steps,
// driving the operand-select mux, ALU op code and accumulator write strobe.
module alu_seq_ctrl #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       START,
  input  logic [2:0] OPCODE,
  output logic [2:0] ALUMUX,
  output logic [2:0] ALUOP,
  output logic       ACC_WE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_FIN} state_e;

  localparam logic [2:0] MUX_IR  = 3'b001;
  localparam logic [2:0] MUX_R5  = 3'b101;
  localparam logic [2:0] MUX_R1  = 3'b100;
  localparam logic [2:0] MUX_IDX = 3'b010;
  localparam logic [2:0] MUX_IDY = 3'b011;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PASS = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;

  localparam logic [2:0] MUL_LAST = 3'(MUL_CYCLES - 1);

  // Step table: returns {ALUMUX, ALUOP} for step idx of macro-op op
  function automatic logic [5:0] f_step(input logic [2:0] op, input logic [1:0] idx);
    case (op)
      3'b001:  f_step = {MUX_IR,  OP_PASS};
      3'b010:  f_step = {MUX_R1,  OP_ADD};
      3'b011:  f_step = {MUX_R1,  OP_SUB};
      3'b100:  f_step = {MUX_R5,  OP_MUL};
      3'b101: begin
        case (idx)
          2'd0:    f_step = {MUX_IDX, OP_PASS};
          2'd1:    f_step = {MUX_IDY, OP_ADD};
          default: f_step = {MUX_R5,  OP_ADD};
        endcase
      end
      3'b110:  f_step = {MUX_IDX, OP_INC};
      default: f_step = {MUX_IR,  OP_NOP};
    endcase
  endfunction

  function automatic logic [1:0] f_last_step(input logic [2:0] op);
    f_last_step = (op == 3'b101) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [2:0] f_last_cnt(input logic [2:0] aop);
    f_last_cnt = (aop == OP_MUL) ? MUL_LAST : 3'd0;
  endfunction

  state_e     r_state;
  logic [2:0] r_op;
  logic [1:0] r_step;
  logic [2:0] r_cnt;

  logic [5:0] w_first;
  logic [5:0] w_next;
  logic       w_legal;
  logic       w_step_end;
  logic       w_seq_end;

  always_comb begin
    w_first    = f_step(OPCODE, 2'd0);
    w_next     = f_step(r_op, r_step + 2'd1);
    w_legal    = (OPCODE != 3'b000) && (OPCODE != 3'b111);
    w_step_end = (r_cnt == f_last_cnt(ALUOP));
    w_seq_end  = w_step_end && (r_step == f_last_step(r_op));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      ALUMUX  <= MUX_IR;
      ALUOP   <= OP_NOP;
      ACC_WE  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (r_state)
        S_STEP: begin
          if (w_seq_end) begin
            r_state <= S_FIN;
            ALUMUX  <= MUX_IR;
            ALUOP   <= OP_NOP;
            ACC_WE  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end else if (w_step_end) begin
            r_step            <= r_step + 2'd1;
            r_cnt             <= '0;
            {ALUMUX, ALUOP}   <= w_next;
            ACC_WE            <= (f_last_cnt(w_next[2:0]) == 3'd0);
          end else begin
            r_cnt  <= r_cnt + 3'd1;
            ACC_WE <= ((r_cnt + 3'd1) == f_last_cnt(ALUOP));
          end
        end
        default: begin
          // IDLE and FIN share acceptance so a new op can follow DONE directly
          if (START && w_legal) begin
            r_state         <= S_STEP;
            r_op            <= OPCODE;
            r_step          <= '0;
            r_cnt           <= '0;
            {ALUMUX, ALUOP} <= w_first;
            ACC_WE          <= (f_last_cnt(w_first[2:0]) == 3'd0);
            BUSY            <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
            ALUMUX  <= MUX_IR;
            ALUOP   <= OP_NOP;
            ACC_WE  <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= START;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: two instances (MUL_CYCLES=3 and 1) share stimulus.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic       START;
  logic [2:0] OPCODE;

  logic [2:0] ALUMUX, ALUOP;
  logic       ACC_WE, BUSY, DONE, ERR;
  logic [2:0] ALUMUX1, ALUOP1;
  logic       ACC_WE1, BUSY1, DONE1, ERR1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_seq_ctrl #(.MUL_CYCLES(3)) u_dut (
    .clk(clk), .rstn(rstn), .START(START), .OPCODE(OPCODE),
    .ALUMUX(ALUMUX), .ALUOP(ALUOP), .ACC_WE(ACC_WE),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  alu_seq_ctrl #(.MUL_CYCLES(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .START(START), .OPCODE(OPCODE),
    .ALUMUX(ALUMUX1), .ALUOP(ALUOP1), .ACC_WE(ACC_WE1),
    .BUSY(BUSY1), .DONE(DONE1), .ERR(ERR1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%03h exp=%03h (mux,op,we,busy,done,err)", tag, got, exp);
    end
  endtask

  task automatic exp0(input string tag, input logic [2:0] mux, input logic [2:0] aop,
                      input logic we, input logic busy, input logic done, input logic err);
    chk(tag, 32'({ALUMUX, ALUOP, ACC_WE, BUSY, DONE, ERR}),
        32'({mux, aop, we, busy, done, err}));
  endtask

  task automatic exp1(input string tag, input logic [2:0] mux, input logic [2:0] aop,
                      input logic we, input logic busy, input logic done, input logic err);
    chk(tag, 32'({ALUMUX1, ALUOP1, ACC_WE1, BUSY1, DONE1, ERR1}),
        32'({mux, aop, we, busy, done, err}));
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one rising edge; returns in cycle 1
  task automatic issue(input logic [2:0] op);
    START  = 1'b1;
    OPCODE = op;
    tick();
    START  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn   = 1'b0;
    START  = 1'b0;
    OPCODE = 3'b000;
    tick();
    tick();
    exp0("reset", 3'b001, 3'b000, 0, 0, 0, 0);
    exp1("reset_m1", 3'b001, 3'b000, 0, 0, 0, 0);
    rstn = 1'b1;
    tick();

    // ADDR: three single-cycle steps
    issue(3'b101);
    exp0("addr_c1", 3'b010, 3'b001, 1, 1, 0, 0);
    tick();
    exp0("addr_c2", 3'b011, 3'b010, 1, 1, 0, 0);
    tick();
    exp0("addr_c3", 3'b101, 3'b010, 1, 1, 0, 0);
    tick();
    exp0("addr_c4", 3'b001, 3'b000, 0, 0, 1, 0);
    tick();
    exp0("addr_c5", 3'b001, 3'b000, 0, 0, 0, 0);

    // MULR5 on both instances
    issue(3'b100);
    exp0("mul3_c1", 3'b101, 3'b100, 0, 1, 0, 0);
    exp1("mul1_c1", 3'b101, 3'b100, 1, 1, 0, 0);
    tick();
    exp0("mul3_c2", 3'b101, 3'b100, 0, 1, 0, 0);
    exp1("mul1_c2", 3'b001, 3'b000, 0, 0, 1, 0);
    tick();
    exp0("mul3_c3", 3'b101, 3'b100, 1, 1, 0, 0);
    exp1("mul1_c3", 3'b001, 3'b000, 0, 0, 0, 0);
    tick();
    exp0("mul3_c4", 3'b001, 3'b000, 0, 0, 1, 0);
    tick();
    exp0("mul3_c5", 3'b001, 3'b000, 0, 0, 0, 0);

    // Illegal opcodes
    issue(3'b111);
    exp0("err111_c1", 3'b001, 3'b000, 0, 0, 0, 1);
    tick();
    exp0("err111_c2", 3'b001, 3'b000, 0, 0, 0, 0);
    issue(3'b000);
    exp0("err000_c1", 3'b001, 3'b000, 0, 0, 0, 1);
    tick();
    exp0("err000_c2", 3'b001, 3'b000, 0, 0, 0, 0);

    // INCX with a second request while busy
    issue(3'b110);
    exp0("incx_c1", 3'b010, 3'b101, 1, 1, 0, 0);
    START  = 1'b1;
    OPCODE = 3'b001;
    tick();
    START  = 1'b0;
    exp0("incx_c2", 3'b001, 3'b000, 0, 0, 1, 0);
    tick();
    exp0("incx_c3", 3'b001, 3'b000, 0, 0, 0, 0);

    // START during FIN chains straight into the next op
    issue(3'b110);
    exp0("chain_c1", 3'b010, 3'b101, 1, 1, 0, 0);
    tick();
    exp0("chain_fin", 3'b001, 3'b000, 0, 0, 1, 0);
    issue(3'b001);
    exp0("chain_ldi", 3'b001, 3'b001, 1, 1, 0, 0);
    tick();
    exp0("chain_done", 3'b001, 3'b000, 0, 0, 1, 0);
    tick();
    exp0("chain_idle", 3'b001, 3'b000, 0, 0, 0, 0);

    // Asynchronous reset in the middle of ADDR
    issue(3'b101);
    tick();
    exp0("arst_pre", 3'b011, 3'b010, 1, 1, 0, 0);
    #2 rstn = 1'b0;
    #1;
    exp0("arst_async", 3'b001, 3'b000, 0, 0, 0, 0);
    tick();
    rstn = 1'b1;
    tick();
    exp0("arst_post1", 3'b001, 3'b000, 0, 0, 0, 0);
    tick();
    exp0("arst_post2", 3'b001, 3'b000, 0, 0, 0, 0);
    issue(3'b010);
    exp0("addr1_c1", 3'b100, 3'b010, 1, 1, 0, 0);
    tick();
    exp0("addr1_c2", 3'b001, 3'b000, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
